// File: rtl/fetch_queue_if.sv
// Fetch unit bus bundle: jump redirect, memory request/response and decode handshake.
// The master side is the fetch unit; the slave side is memory plus decode.
interface fetch_queue_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             jmp;
  logic [WIDTH-1:0] jaddr;
  logic             req_valid;
  logic [WIDTH-1:0] req_addr;
  logic             req_ready;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic             inst_valid;
  logic             inst_ready;
  logic [WIDTH-1:0] inst;
  logic [WIDTH-1:0] inst_addr;

  modport master (
    input  jmp, jaddr, req_ready, resp_valid, resp_data, inst_ready,
    output req_valid, req_addr, inst_valid, inst, inst_addr
  );

  modport slave (
    output jmp, jaddr, req_ready, resp_valid, resp_data, inst_ready,
    input  req_valid, req_addr, inst_valid, inst, inst_addr
  );
endinterface

// File: rtl/fetch_queue.sv
// Prefetching instruction fetch unit: credit-limited sequential fetch into a DEPTH-entry
// instruction FIFO, with jump flush that discards responses still owed by memory.
module fetch_queue #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      DEPTH      = 4,
  parameter int unsigned      MAX_OUT    = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter logic [WIDTH-1:0] NOP        = WIDTH'(32'h13)
) (
  input  logic           clk,
  input  logic           rst,
  fetch_queue_if.master  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(MAX_OUT + 1);
  localparam int unsigned AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned SW = ((CW > IW) ? CW : IW) + 1;

  logic             jmp;
  logic [WIDTH-1:0] jaddr;
  logic             req_ready;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic             inst_ready;

  assign jmp        = bus.jmp;
  assign jaddr      = bus.jaddr;
  assign req_ready  = bus.req_ready;
  assign resp_valid = bus.resp_valid;
  assign resp_data  = bus.resp_data;
  assign inst_ready = bus.inst_ready;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] fifo_data_q [DEPTH];
  logic [WIDTH-1:0] fifo_data_d [DEPTH];
  logic [WIDTH-1:0] fifo_addr_q [DEPTH];
  logic [WIDTH-1:0] fifo_addr_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [IW-1:0]    inflight_q, inflight_d;
  logic [IW-1:0]    drop_q, drop_d;
  logic [WIDTH-1:0] aq_q [MAX_OUT];
  logic [WIDTH-1:0] aq_d [MAX_OUT];
  logic [AW-1:0]    aq_wr_q, aq_wr_d;
  logic [AW-1:0]    aq_rd_q, aq_rd_d;

  logic [SW-1:0]    used_c;
  logic             req_valid_c;
  logic             issue_c;
  logic             resp_fire_c;
  logic             inst_valid_c;
  logic             pop_c;
  logic             push_c;

  // Credit = words buffered plus live (non-discarded) requests; it bounds the FIFO fill.
  assign used_c       = SW'(count_q) + SW'(inflight_q) - SW'(drop_q);
  assign req_valid_c  = rst & ~jmp & (inflight_q < IW'(MAX_OUT)) & (used_c < SW'(DEPTH));
  assign issue_c      = req_valid_c & req_ready;
  assign resp_fire_c  = rst & resp_valid & (inflight_q != '0);
  assign inst_valid_c = rst & ~jmp & (count_q != '0);
  assign pop_c        = inst_valid_c & inst_ready;
  assign push_c       = resp_fire_c & ~jmp & (drop_q == '0);

  always_comb begin
    pc_d        = pc_q;
    fifo_data_d = fifo_data_q;
    fifo_addr_d = fifo_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    aq_d        = aq_q;
    aq_wr_d     = aq_wr_q;
    aq_rd_d     = aq_rd_q;
    drop_d      = drop_q;
    inflight_d  = inflight_q + IW'(issue_c) - IW'(resp_fire_c);
    count_d     = count_q + CW'(push_c) - CW'(pop_c);

    // Request addresses are queued so each response can be tagged with its fetch address.
    if (issue_c) begin
      aq_d[aq_wr_q] = pc_q;
      aq_wr_d       = (aq_wr_q == AW'(MAX_OUT - 1)) ? '0 : aq_wr_q + AW'(1);
      pc_d          = pc_q + WIDTH'(4);
    end

    if (resp_fire_c) begin
      aq_rd_d = (aq_rd_q == AW'(MAX_OUT - 1)) ? '0 : aq_rd_q + AW'(1);
      if (drop_q != '0) begin
        drop_d = drop_q - IW'(1);
      end
    end

    if (push_c) begin
      fifo_data_d[wr_ptr_q] = resp_data;
      fifo_addr_d[wr_ptr_q] = aq_q[aq_rd_q];
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end

    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Every response still owed after this cycle belongs to the abandoned stream.
    if (jmp) begin
      pc_d     = jaddr;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      drop_d   = inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_ADDR;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      aq_wr_q    <= '0;
      aq_rd_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      aq_wr_q    <= aq_wr_d;
      aq_rd_q    <= aq_rd_d;
    end
  end

  // Storage needs no reset: pointers and counts decide which entries are meaningful.
  always_ff @(posedge clk) begin
    fifo_data_q <= fifo_data_d;
    fifo_addr_q <= fifo_addr_d;
    aq_q        <= aq_d;
  end

  assign bus.req_valid  = req_valid_c;
  assign bus.req_addr   = rst ? pc_q : RESET_ADDR;
  assign bus.inst_valid = inst_valid_c;
  assign bus.inst       = inst_valid_c ? fifo_data_q[rd_ptr_q] : NOP;
  assign bus.inst_addr  = inst_valid_c ? fifo_addr_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: scenario tasks plus a randomized run against a queue-based
// model of the fetch stream (epoch-tagged requests, in-order memory, instruction FIFO).
module tb_fetch_queue;

  localparam int          DEPTH   = 4;
  localparam int          MAX_OUT = 4;
  localparam logic [31:0] NOP     = 32'h13;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  logic clk;
  logic rst;

  fetch_queue_if #(.WIDTH(32)) bus ();

  fetch_queue #(
    .WIDTH(32), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_ADDR(32'h0), .NOP(NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int cyc;
  int lat_min;
  int lat_max;

  mreq_t       mem_q [$];
  logic [31:0] m_fifo [$];
  logic [31:0] m_pc;
  int          m_epoch;

  logic        exp_req_valid, exp_inst_valid;
  logic [31:0] exp_req_addr, exp_inst, exp_inst_addr;
  logic        obs_req_valid, obs_inst_valid;
  logic [31:0] obs_req_addr, obs_inst, obs_inst_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // One clock: drive inputs at negedge, sample 1ns later, then advance the model to the next edge.
  task automatic step(input logic r, input logic j, input logic [31:0] ja,
                      input logic rr, input logic ir, input logic stray);
    int    live;
    bit    have;
    mreq_t e;
    int    due;
    @(negedge clk);
    have = r && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rst            = r;
    bus.jmp        = j;
    bus.jaddr      = ja;
    bus.req_ready  = rr;
    bus.inst_ready = ir;
    if (have) begin
      bus.resp_valid = 1'b1;
      bus.resp_data  = mem_word(mem_q[0].addr);
    end else if (stray) begin
      bus.resp_valid = 1'b1;
      bus.resp_data  = $urandom;
    end else begin
      bus.resp_valid = 1'b0;
      bus.resp_data  = 32'hDEAD_BEEF;
    end
    live = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch == m_epoch) live++;
    exp_req_valid  = r && !j && (mem_q.size() < MAX_OUT) && (m_fifo.size() + live < DEPTH);
    exp_req_addr   = r ? m_pc : 32'h0;
    exp_inst_valid = r && !j && (m_fifo.size() > 0);
    exp_inst_addr  = exp_inst_valid ? m_fifo[0] : 32'h0;
    exp_inst       = exp_inst_valid ? mem_word(m_fifo[0]) : NOP;
    #1;
    obs_req_valid  = bus.req_valid;
    obs_req_addr   = bus.req_addr;
    obs_inst_valid = bus.inst_valid;
    obs_inst       = bus.inst;
    obs_inst_addr  = bus.inst_addr;
    if (!r) begin
      mem_q.delete();
      m_fifo.delete();
      m_pc = 32'h0;
      m_epoch++;
    end else begin
      if (exp_inst_valid && ir) void'(m_fifo.pop_front());
      if (have) begin
        e = mem_q.pop_front();
        if (!j && e.epoch == m_epoch) m_fifo.push_back(e.addr);
      end
      if (exp_req_valid && rr) begin
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (mem_q.size() > 0 && mem_q[$].due >= due) due = mem_q[$].due + 1;
        mem_q.push_back('{m_pc, m_epoch, due});
        m_pc = m_pc + 32'd4;
      end
      if (j) begin
        m_fifo.delete();
        m_pc = ja;
        m_epoch++;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    lat_min = 1;
    lat_max = 1;
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (obs_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b want=0", obs_req_valid); end
    total++; if (obs_req_addr !== 32'h0) begin bad++; $display("FAIL reset_req_addr got=%h want=0", obs_req_addr); end
    total++; if (obs_inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid got=%b want=0", obs_inst_valid); end
    total++; if (obs_inst !== NOP) begin bad++; $display("FAIL reset_inst got=%h want=%h", obs_inst, NOP); end
    total++; if (obs_inst_addr !== 32'h0) begin bad++; $display("FAIL reset_inst_addr got=%h want=0", obs_inst_addr); end
  endtask

  task automatic test_stream();
    int first_iss, first_val, nreq, npop;
    first_iss = -1; first_val = -1; nreq = 0; npop = 0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      if (obs_req_valid === 1'b1) begin
        if (first_iss < 0) first_iss = k;
        total++;
        if (obs_req_addr !== 32'(nreq * 4)) begin
          bad++; $display("FAIL stream_req_addr got=%h want=%h", obs_req_addr, 32'(nreq * 4));
        end
        nreq++;
      end
      if (obs_inst_valid === 1'b1) begin
        if (first_val < 0) first_val = k;
        total++;
        if (obs_inst_addr !== 32'(npop * 4) || obs_inst !== mem_word(32'(npop * 4))) begin
          bad++; $display("FAIL stream_inst got=%h@%h want=%h@%h", obs_inst, obs_inst_addr,
                          mem_word(32'(npop * 4)), 32'(npop * 4));
        end
        npop++;
      end else if (first_val >= 0) begin
        total++; bad++; $display("FAIL stream_bubble got=inst_valid 0 want=1 at step %0d", k);
      end
    end
    total++; if (first_iss < 0 || first_val != first_iss + 2) begin
      bad++; $display("FAIL stream_latency got=%0d want=%0d", first_val - first_iss, 2);
    end
    total++; if (npop < 12) begin bad++; $display("FAIL stream_count got=%0d want>=12", npop); end
  endtask

  task automatic test_backpressure();
    int npop;
    bit req_seen;
    npop = 0; req_seen = 0;
    do_reset();
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    total++; if (obs_req_valid !== 1'b0) begin bad++; $display("FAIL full_req_valid got=%b want=0", obs_req_valid); end
    total++; if (obs_req_addr !== 32'h10) begin bad++; $display("FAIL full_req_addr got=%h want=00000010", obs_req_addr); end
    total++; if (obs_inst_valid !== 1'b1 || obs_inst_addr !== 32'h0) begin
      bad++; $display("FAIL full_head got=%b@%h want=1@00000000", obs_inst_valid, obs_inst_addr);
    end
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      if (obs_inst_valid === 1'b1 && npop < 4) begin
        total++;
        if (obs_inst_addr !== 32'(npop * 4) || obs_inst !== mem_word(32'(npop * 4))) begin
          bad++; $display("FAIL drain_inst got=%h@%h want=%h@%h", obs_inst, obs_inst_addr,
                          mem_word(32'(npop * 4)), 32'(npop * 4));
        end
        npop++;
      end
      if (obs_req_valid === 1'b1 && !req_seen) begin
        req_seen = 1;
        total++; if (obs_req_addr !== 32'h10) begin
          bad++; $display("FAIL resume_req_addr got=%h want=00000010", obs_req_addr);
        end
      end
    end
    total++; if (npop != 4 || !req_seen) begin
      bad++; $display("FAIL drain_count got=%0d/%0d want=4/1", npop, req_seen);
    end
  endtask

  task automatic test_jump_inflight();
    logic [31:0] nexp;
    do_reset();
    lat_min = 6; lat_max = 6;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0);
    total++; if (obs_req_valid !== 1'b0 || obs_inst_valid !== 1'b0) begin
      bad++; $display("FAIL jmp_cycle got=req%b inst%b want=0 0", obs_req_valid, obs_inst_valid);
    end
    nexp = 32'h100;
    for (int k = 0; k < 30; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      if (k == 0) begin
        total++; if (obs_req_valid !== 1'b1 || obs_req_addr !== 32'h100) begin
          bad++; $display("FAIL jmp_target got=%b@%h want=1@00000100", obs_req_valid, obs_req_addr);
        end
      end
      if (obs_inst_valid === 1'b1) begin
        total++;
        if (obs_inst_addr !== nexp || obs_inst !== mem_word(nexp)) begin
          bad++; $display("FAIL jmp_stream got=%h@%h want=%h@%h", obs_inst, obs_inst_addr, mem_word(nexp), nexp);
        end
        nexp = nexp + 32'd4;
      end
    end
    total++; if (nexp == 32'h100) begin bad++; $display("FAIL jmp_no_inst got=none want=00000100"); end
  endtask

  task automatic test_jump_collision();
    bit got;
    got = 0;
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0);
    total++; if (obs_inst_valid !== 1'b0 || obs_req_valid !== 1'b0) begin
      bad++; $display("FAIL coll_jmp got=inst%b req%b want=0 0", obs_inst_valid, obs_req_valid);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    total++; if (obs_inst_valid !== 1'b0 || obs_inst !== NOP) begin
      bad++; $display("FAIL coll_flush got=%b/%h want=0/%h", obs_inst_valid, obs_inst, NOP);
    end
    total++; if (obs_req_valid !== 1'b1 || obs_req_addr !== 32'h200) begin
      bad++; $display("FAIL coll_restart got=%b@%h want=1@00000200", obs_req_valid, obs_req_addr);
    end
    for (int k = 0; k < 10 && !got; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      if (obs_inst_valid === 1'b1) begin
        got = 1;
        total++; if (obs_inst_addr !== 32'h200 || obs_inst !== mem_word(32'h200)) begin
          bad++; $display("FAIL coll_first got=%h@%h want=%h@00000200", obs_inst, obs_inst_addr, mem_word(32'h200));
        end
      end
    end
    total++; if (!got) begin bad++; $display("FAIL coll_hang got=no inst_valid want=inst within 10 cycles"); end
  endtask

  task automatic test_mid_reset();
    bit got;
    got = 0;
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    total++; if (obs_req_addr !== 32'h0 || obs_req_valid !== 1'b1) begin
      bad++; $display("FAIL mrst_req got=%b@%h want=1@00000000", obs_req_valid, obs_req_addr);
    end
    total++; if (obs_inst_valid !== 1'b0 || obs_inst !== NOP || obs_inst_addr !== 32'h0) begin
      bad++; $display("FAIL mrst_inst got=%b %h@%h want=0 %h@0", obs_inst_valid, obs_inst, obs_inst_addr, NOP);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    total++; if (obs_inst_valid !== 1'b0) begin
      bad++; $display("FAIL mrst_stray got=inst_valid %b want=0", obs_inst_valid);
    end
    for (int k = 0; k < 8 && !got; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      if (obs_inst_valid === 1'b1) begin
        got = 1;
        total++; if (obs_inst_addr !== 32'h0 || obs_inst !== mem_word(32'h0)) begin
          bad++; $display("FAIL mrst_first got=%h@%h want=%h@00000000", obs_inst, obs_inst_addr, mem_word(32'h0));
        end
      end
    end
    total++; if (!got) begin bad++; $display("FAIL mrst_hang got=no inst_valid want=inst within 8 cycles"); end
  endtask

  task automatic test_random();
    logic        j, rr, ir;
    logic [31:0] ja;
    int          pops;
    pops = 0;
    do_reset();
    lat_min = 1; lat_max = 3;
    for (int k = 0; k < 3000; k++) begin
      j  = ($urandom_range(0, 99) < 3);
      rr = ($urandom_range(0, 3) != 0);
      ir = ($urandom_range(0, 9) < 7);
      ja = 32'($urandom_range(0, 1023)) << 2;
      step(1'b1, j, ja, rr, ir, 1'b0);
      if (exp_inst_valid && ir) pops++;
      total++; if (obs_req_valid !== exp_req_valid) begin
        bad++; $display("FAIL rnd_req_valid c%0d got=%b want=%b", k, obs_req_valid, exp_req_valid);
      end
      total++; if (obs_req_addr !== exp_req_addr) begin
        bad++; $display("FAIL rnd_req_addr c%0d got=%h want=%h", k, obs_req_addr, exp_req_addr);
      end
      total++; if (obs_inst_valid !== exp_inst_valid) begin
        bad++; $display("FAIL rnd_inst_valid c%0d got=%b want=%b", k, obs_inst_valid, exp_inst_valid);
      end
      total++; if (obs_inst_addr !== exp_inst_addr) begin
        bad++; $display("FAIL rnd_inst_addr c%0d got=%h want=%h", k, obs_inst_addr, exp_inst_addr);
      end
      total++; if (obs_inst !== exp_inst) begin
        bad++; $display("FAIL rnd_inst c%0d got=%h want=%h", k, obs_inst, exp_inst);
      end
    end
    total++; if (pops < 500) begin bad++; $display("FAIL rnd_progress got=%0d want>=500", pops); end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; m_epoch = 0; m_pc = 32'h0;
    lat_min = 1; lat_max = 1;
    rst = 1'b0;
    bus.jmp = 1'b0; bus.jaddr = 32'h0; bus.req_ready = 1'b0;
    bus.resp_valid = 1'b0; bus.resp_data = 32'h0; bus.inst_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_jump_inflight();
    test_jump_collision();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
